// File: rtl/proctypes.sv
// Shared types for the render front end: camera record, scheduler states,
// pixel job record and a small modular-add helper used for round-robin math.
package proctypes;

  // Largest tracer pool the scheduler is meant to drive.
  localparam int MAX_TRACERS = 16;

  // Camera pose handed from the instruction processor to the tracers.
  typedef struct packed {
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] pos_z;
    logic [15:0] yaw;
  } Camera;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEM,
    DISPATCH,
    DRAIN,
    DONE
  } SchedState;

  // One unit of work for a tracer.
  typedef struct packed {
    logic [15:0] hcount;
    logic [15:0] vcount;
    Camera       camera;
  } PixelJob;

  // (a + b) mod n; callers keep a and b below n so the sum never overflows.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/render_scheduler_rr_picker.sv
// Round-robin picker: finds the first free tracer at or after the pointer,
// wrapping around the pool. Purely combinational.
module rr_picker
  import proctypes::*;
#(
  parameter int NUM_TRACERS = 4,
  localparam int IW = (NUM_TRACERS > 1) ? $clog2(NUM_TRACERS) : 1
) (
  input  logic [NUM_TRACERS-1:0] free_mask,
  input  logic [IW-1:0]          rr_ptr,
  output logic                   found,
  output logic [IW-1:0]          pick_idx
);

  // rotated[i] is the free bit of tracer (rr_ptr + i) mod NUM_TRACERS
  logic [NUM_TRACERS-1:0] rotated;
  logic [IW-1:0]          offset;

  for (genvar gi = 0; gi < NUM_TRACERS; gi++) begin : g_rot
    assign rotated[gi] = free_mask[IW'(wrap_add(32'(rr_ptr), 32'(gi), 32'(NUM_TRACERS)))];
  end

  // Lowest set bit of the rotated mask is the nearest free tracer.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = NUM_TRACERS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = IW'(i);
      end
    end
  end

  assign pick_idx = IW'(wrap_add(32'(rr_ptr), 32'(offset), 32'(NUM_TRACERS)));

endmodule

// File: rtl/render_scheduler.sv
// Frame render scheduler: waits for scene memory, walks pixels in raster
// order, offers one job at a time to the first idle tracer (round-robin),
// counts completions and pulses frame_done when the frame has retired.
// Optional stall counter output enabled by defining RENDER_SCHED_PERF_EN.
module render_scheduler
  import proctypes::*;
#(
  parameter int NUM_TRACERS = 4,
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  localparam int HW = $clog2(H_RES),
  localparam int VW = $clog2(V_RES),
  localparam int PW = $clog2(H_RES * V_RES + 1),
  localparam int IW = (NUM_TRACERS > 1) ? $clog2(NUM_TRACERS) : 1
) (
  input  logic                   clk_100mhz,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mem_ready,
  input  Camera                  cam_in,
  output logic [NUM_TRACERS-1:0] job_valid,
  input  logic [NUM_TRACERS-1:0] job_ready,
  output logic [HW-1:0]          job_hcount,
  output logic [VW-1:0]          job_vcount,
  output Camera                  job_camera,
  input  logic [NUM_TRACERS-1:0] done_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic [PW-1:0]          pixels_done
`ifdef RENDER_SCHED_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  SchedState              state_reg, state_next;
  logic [HW-1:0]          x_reg;
  logic [VW-1:0]          y_reg;
  logic [IW-1:0]          rr_reg;
  logic [IW-1:0]          offer_idx_reg;
  logic [NUM_TRACERS-1:0] busy_mask_reg, busy_mask_next;
  logic [NUM_TRACERS-1:0] job_valid_reg;
  logic [HW-1:0]          job_hcount_reg;
  logic [VW-1:0]          job_vcount_reg;
  Camera                  job_camera_reg;
  logic [PW-1:0]          pixels_done_reg, pixels_done_next;

  logic [NUM_TRACERS-1:0] xfer_mask;
  logic                   xfer, last_pixel, frame_start, pick_en, found;
  logic [IW-1:0]          pick_idx;

  assign frame_start = (state_reg == IDLE) && start;
  assign xfer_mask   = job_valid_reg & job_ready;
  assign xfer        = |xfer_mask;
  assign last_pixel  = (x_reg == HW'(H_RES - 1)) && (y_reg == VW'(V_RES - 1));
  // Only pick when nothing is on offer, so a pending offer is never moved.
  assign pick_en     = (state_reg == DISPATCH) && mem_ready && !(|job_valid_reg) && found;

  // Completions use the registered mask, so a tracer finishing this cycle is
  // only seen as free by the picker on the next cycle.
  assign busy_mask_next   = (busy_mask_reg & ~done_valid) | xfer_mask;
  assign pixels_done_next = pixels_done_reg + PW'($countones(done_valid & busy_mask_reg));

  rr_picker #(.NUM_TRACERS(NUM_TRACERS)) u_picker (
    .free_mask (~busy_mask_reg),
    .rr_ptr    (rr_reg),
    .found     (found),
    .pick_idx  (pick_idx)
  );

  // State register.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start)                                      state_next = WAIT_MEM;
      WAIT_MEM: if (mem_ready)                                  state_next = DISPATCH;
      DISPATCH: if (xfer && last_pixel)                         state_next = DRAIN;
      DRAIN:    if (pixels_done_next == PW'(H_RES * V_RES))     state_next = DONE;
      DONE:                                                     state_next = IDLE;
      default:                                                  state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy       = (state_reg != IDLE);
    frame_done = (state_reg == DONE);
  end

  // Dispatch datapath: frame setup, offer/transfer handling and completion count.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      rr_reg          <= '0;
      offer_idx_reg   <= '0;
      busy_mask_reg   <= '0;
      job_valid_reg   <= '0;
      job_hcount_reg  <= '0;
      job_vcount_reg  <= '0;
      job_camera_reg  <= '0;
      pixels_done_reg <= '0;
    end else if (frame_start) begin
      job_camera_reg  <= cam_in;
      x_reg           <= '0;
      y_reg           <= '0;
      pixels_done_reg <= '0;
      busy_mask_reg   <= '0;
    end else begin
      busy_mask_reg   <= busy_mask_next;
      pixels_done_reg <= pixels_done_next;
      if (xfer) begin
        job_valid_reg <= '0;
        rr_reg        <= IW'(wrap_add(32'(offer_idx_reg), 32'd1, 32'(NUM_TRACERS)));
        if (x_reg == HW'(H_RES - 1)) begin
          x_reg <= '0;
          y_reg <= y_reg + VW'(1);
        end else begin
          x_reg <= x_reg + HW'(1);
        end
      end else if (pick_en) begin
        job_valid_reg  <= NUM_TRACERS'(1) << pick_idx;
        offer_idx_reg  <= pick_idx;
        job_hcount_reg <= x_reg;
        job_vcount_reg <= y_reg;
      end
    end
  end

  assign job_valid   = job_valid_reg;
  assign job_hcount  = job_hcount_reg;
  assign job_vcount  = job_vcount_reg;
  assign job_camera  = job_camera_reg;
  assign pixels_done = pixels_done_reg;

`ifdef RENDER_SCHED_PERF_EN
  logic [31:0] stall_cycles_reg;

  // Count DISPATCH cycles that moved no job, saturating at all-ones.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst)                                                           stall_cycles_reg <= '0;
    else if (frame_start)                                              stall_cycles_reg <= '0;
    else if (state_reg == DISPATCH && !xfer && stall_cycles_reg != '1) stall_cycles_reg <= stall_cycles_reg + 32'd1;
  end

  assign stall_cycles = stall_cycles_reg;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_render_scheduler.sv
// Randomized bench for render_scheduler against a raster-index reference model.
module tb_render_scheduler;
  import proctypes::*;

  localparam int N     = 2;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int TOTAL = H * V;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_DISP  = 2;
  localparam int PH_DRAIN = 3;
  localparam int PH_DONE  = 4;

  logic                     clk_100mhz = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     mem_ready;
  Camera                    cam_in;
  logic [N-1:0]             job_valid;
  logic [N-1:0]             job_ready;
  logic [$clog2(H)-1:0]     job_hcount;
  logic [$clog2(V)-1:0]     job_vcount;
  Camera                    job_camera;
  logic [N-1:0]             done_valid;
  logic                     busy;
  logic                     frame_done;
  logic [$clog2(TOTAL+1)-1:0] pixels_done;
`ifdef RENDER_SCHED_PERF_EN
  logic [31:0]              stall_cycles;
`endif

  render_scheduler #(.NUM_TRACERS(N), .H_RES(H), .V_RES(V)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .start      (start),
    .mem_ready  (mem_ready),
    .cam_in     (cam_in),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_hcount (job_hcount),
    .job_vcount (job_vcount),
    .job_camera (job_camera),
    .done_valid (done_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .pixels_done(pixels_done)
`ifdef RENDER_SCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_checks;
  int n_errors;

  // Reference model: phase, pending offer, busy tracers, raster index.
  int           m_ph;
  bit           m_valid;
  int           m_tgt;
  int           m_rr;
  int           m_p;
  int           m_cnt;
  logic [N-1:0] m_busy;
  Camera        m_cam;
  logic [31:0]  m_stall;
  int           m_jobs;

  int tmr[N];
  int pend0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_valid = 0; m_tgt = 0; m_rr = 0; m_p = 0; m_cnt = 0;
    m_busy = '0; m_cam = '0; m_stall = '0;
    for (int k = 0; k < N; k++) tmr[k] = 0;
    pend0 = 0;
  endtask

  // Advance the model across one rising edge using the inputs held during that cycle.
  task automatic model_edge(output int acc);
    bit           xfer;
    int           nph;
    int           cnt_n;
    logic [N-1:0] busy_n;
    acc = -1;
    if (m_ph == PH_IDLE) begin
      if (start) begin
        m_ph = PH_WAIT; m_cam = cam_in; m_p = 0; m_cnt = 0; m_busy = '0; m_stall = '0;
      end
    end else begin
      xfer   = m_valid && job_ready[m_tgt];
      busy_n = m_busy & ~done_valid;
      cnt_n  = m_cnt + $countones(done_valid & m_busy);
      nph    = m_ph;
      if (m_ph == PH_DISP && !xfer && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (xfer) begin
        m_jobs++;
        $display("job %0d: tracer %0d pixel (%0d,%0d)", m_jobs, m_tgt, m_p % H, m_p / H);
        busy_n[m_tgt] = 1'b1;
        acc     = m_tgt;
        m_rr    = (m_tgt + 1) % N;
        m_valid = 0;
        if (m_p == TOTAL - 1) nph = PH_DRAIN;
        m_p++;
      end else if (m_ph == PH_DISP && mem_ready && !m_valid) begin
        for (int o = 0; o < N; o++) begin
          int c;
          c = (m_rr + o) % N;
          if (!m_busy[c] && !m_valid) begin
            m_valid = 1;
            m_tgt   = c;
          end
        end
      end
      if (m_ph == PH_WAIT && mem_ready)      nph = PH_DISP;
      if (m_ph == PH_DRAIN && cnt_n == TOTAL) nph = PH_DONE;
      if (m_ph == PH_DONE)                   nph = PH_IDLE;
      m_busy = busy_n;
      m_cnt  = cnt_n;
      m_ph   = nph;
    end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] ev;
    PixelJob      exp_job;
    ev = '0;
    if (m_valid) ev[m_tgt] = 1'b1;
    check("job_valid", 64'(job_valid), 64'(ev));
    if (m_valid) begin
      exp_job.hcount = 16'(m_p % H);
      exp_job.vcount = 16'(m_p / H);
      exp_job.camera = m_cam;
      check("job_hcount", 64'(job_hcount), 64'(exp_job.hcount));
      check("job_vcount", 64'(job_vcount), 64'(exp_job.vcount));
    end
    check("job_camera", 64'(job_camera), 64'(m_cam));
    check("busy", 64'(busy), 64'(m_ph != PH_IDLE));
    check("frame_done", 64'(frame_done), 64'(m_ph == PH_DONE));
    check("pixels_done", 64'(pixels_done), 64'(m_cnt));
`ifdef RENDER_SCHED_PERF_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
  endtask

  function automatic int delay_for(input int mode, input int k);
    if (mode == 3) return (k == 0) ? 5 : 3;
    if (mode == 4) return int'($urandom_range(1, 6));
    return 3;
  endfunction

  task automatic idle_inputs();
    start = 0; mem_ready = 0; job_ready = '0; done_valid = '0;
  endtask

  // Choose the inputs for the coming cycle.
  task automatic drive(input int mode, input int cyc);
    start = (cyc == 0);
    if (mode == 4 && cyc != 0 && $urandom_range(0, 19) == 0) start = 1;
    case (mode)
      1:       mem_ready = (cyc > 10);
      4:       mem_ready = ($urandom_range(0, 99) < 85);
      default: mem_ready = 1;
    endcase
    if (m_valid && m_tgt == 0) pend0++;
    else                       pend0 = 0;
    case (mode)
      2:       job_ready = {1'b1, (pend0 > 5)};
      4:       job_ready = N'($urandom_range(0, (1 << N) - 1));
      5:       job_ready = {($urandom_range(0, 9) == 0), 1'b1};
      default: job_ready = '1;
    endcase
    for (int k = 0; k < N; k++) begin
      done_valid[k] = 1'b0;
      if (tmr[k] > 0) begin
        tmr[k]--;
        if (tmr[k] == 0) done_valid[k] = 1'b1;
      end else if ((mode == 3 || mode == 4) && !m_busy[k] && $urandom_range(0, 9) == 0) begin
        done_valid[k] = 1'b1;
      end
    end
  endtask

  task automatic do_abort();
    rst = 1;
    #1;
    check("rst_job_valid", 64'(job_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_pixels_done", 64'(pixels_done), 64'd0);
    check("rst_job_hcount", 64'(job_hcount), 64'd0);
    check("rst_job_vcount", 64'(job_vcount), 64'd0);
    check("rst_job_camera", 64'(job_camera), 64'd0);
`ifdef RENDER_SCHED_PERF_EN
    check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    model_reset();
    idle_inputs();
    @(negedge clk_100mhz);
    rst = 0;
  endtask

  task automatic run_frame(input int mode, input bit abort3);
    int cyc;
    int acc;
    int pulses;
    int dut_xfers;
    bit aborted;
    cyc = 0; pulses = 0; dut_xfers = 0; aborted = 0;
    cam_in = Camera'({$urandom(), $urandom()});
    drive(mode, cyc);
    while (1) begin
      if (|(job_valid & job_ready)) dut_xfers++;
      @(posedge clk_100mhz);
      @(negedge clk_100mhz);
      model_edge(acc);
      compare_outputs();
      if (frame_done) pulses++;
      cyc++;
      if (acc >= 0) tmr[acc] = delay_for(mode, acc);
      if (m_ph == PH_IDLE) break;
      if (cyc >= 3000) begin
        check("frame_timeout", 64'd0, 64'd1);
        break;
      end
      if (abort3 && m_ph == PH_DISP && m_cnt == 3) begin
        do_abort();
        aborted = 1;
        break;
      end
      drive(mode, cyc);
    end
    idle_inputs();
    if (abort3) begin
      check("abort_reached", 64'(aborted), 64'd1);
    end else begin
      check("frame_done_pulses", 64'(pulses), 64'd1);
      check("frame_transfers", 64'(dut_xfers), 64'(TOTAL));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_jobs   = 0;
    rst      = 1;
    cam_in   = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk_100mhz);
    compare_outputs();
    check("reset_job_hcount", 64'(job_hcount), 64'd0);
    check("reset_job_vcount", 64'(job_vcount), 64'd0);
    rst = 0;
    @(negedge clk_100mhz);

    run_frame(0, 0);               // always ready, done 3 cycles after accept
    run_frame(1, 0);               // mem_ready held low after start
    run_frame(2, 0);               // tracer 0 stalls its accept for 5 cycles
    run_frame(3, 0);               // coincident completions, spurious done pulses
    repeat (3) run_frame(4, 0);    // fully random handshakes
    run_frame(5, 0);               // tracer 1 rarely ready, heavy stalling
    run_frame(0, 1);               // reset in DISPATCH at pixels_done == 3
    run_frame(0, 0);               // re-render from (0,0) after abort

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
